// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: default sizes, operand widths
// and the funct3 encodings that the integer ALU decodes.
package alu_rs_pkg;

   localparam int ROB_BIT_DEF = 4;
   localparam int RS_SIZE_DEF = 8;
   localparam int RS_BIT_DEF  = 3;
   localparam int XLEN        = 32;
   localparam int IMM_W       = 5;
   localparam int OP_W        = 3;

   typedef enum logic [OP_W-1:0] {
      AddSub = 3'b000,
      Sll    = 3'b001,
      Slt    = 3'b010,
      Sltu   = 3'b011,
      Xor    = 3'b100,
      SrlSra = 3'b101,
      Or     = 3'b110,
      And    = 3'b111
   } alu_op_e;

endpackage

// File: rtl/rs_pick_lowest.sv
// Priority encoder: reports whether any request bit is set and the index of the
// lowest set bit.
module rs_pick_lowest #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scanning downward leaves the lowest set index as the final assignment.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU: holds dispatched ops until both
// operands are known, snoops the ALU and LSB CDBs, and issues one ready op per cycle.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF,
   parameter int RS_BIT  = RS_BIT_DEF,
   parameter int ROB_BIT = ROB_BIT_DEF
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               clear,
   input  logic               in_valid,
   input  logic [OP_W-1:0]    in_op,
   input  logic               in_op_addition,
   input  logic               in_has_imm,
   input  logic [IMM_W-1:0]   in_imm,
   input  logic [XLEN-1:0]    in_vi,
   input  logic [XLEN-1:0]    in_vj,
   input  logic               in_qi_busy,
   input  logic               in_qj_busy,
   input  logic [ROB_BIT-1:0] in_qi,
   input  logic [ROB_BIT-1:0] in_qj,
   input  logic [ROB_BIT-1:0] in_rob_entry,
   output logic               full,
   input  logic               cdb_alu_valid,
   input  logic [ROB_BIT-1:0] cdb_alu_rob,
   input  logic [XLEN-1:0]    cdb_alu_val,
   input  logic               cdb_lsb_valid,
   input  logic [ROB_BIT-1:0] cdb_lsb_rob,
   input  logic [XLEN-1:0]    cdb_lsb_val,
   output logic               alu_valid,
   output logic [XLEN-1:0]    alu_vi,
   output logic [XLEN-1:0]    alu_vj,
   output logic [IMM_W-1:0]   alu_imm,
   output logic [OP_W-1:0]    alu_op,
   output logic               alu_has_imm,
   output logic               alu_op_addition,
   output logic [ROB_BIT-1:0] alu_rob_entry
);

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [RS_SIZE-1:0] qi_busy_q, qi_busy_d;
   logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
   logic [RS_SIZE-1:0] add_q, add_d;
   logic [RS_SIZE-1:0] has_imm_q, has_imm_d;
   alu_op_e            op_q  [RS_SIZE];
   alu_op_e            op_d  [RS_SIZE];
   logic [IMM_W-1:0]   imm_q [RS_SIZE];
   logic [IMM_W-1:0]   imm_d [RS_SIZE];
   logic [XLEN-1:0]    vi_q  [RS_SIZE];
   logic [XLEN-1:0]    vi_d  [RS_SIZE];
   logic [XLEN-1:0]    vj_q  [RS_SIZE];
   logic [XLEN-1:0]    vj_d  [RS_SIZE];
   logic [ROB_BIT-1:0] qi_q  [RS_SIZE];
   logic [ROB_BIT-1:0] qi_d  [RS_SIZE];
   logic [ROB_BIT-1:0] qj_q  [RS_SIZE];
   logic [ROB_BIT-1:0] qj_d  [RS_SIZE];
   logic [ROB_BIT-1:0] rob_q [RS_SIZE];
   logic [ROB_BIT-1:0] rob_d [RS_SIZE];

   logic               alu_valid_q, alu_valid_d;
   logic [XLEN-1:0]    alu_vi_q, alu_vi_d;
   logic [XLEN-1:0]    alu_vj_q, alu_vj_d;
   logic [IMM_W-1:0]   alu_imm_q, alu_imm_d;
   alu_op_e            alu_op_q, alu_op_d;
   logic               alu_has_imm_q, alu_has_imm_d;
   logic               alu_add_q, alu_add_d;
   logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

   logic [RS_SIZE-1:0] free_vec, ready_vec;
   logic               free_found, ready_found;
   logic [RS_BIT-1:0]  free_idx, ready_idx;

   logic [XLEN-1:0]    ins_vi, ins_vj;
   logic               ins_qi_busy, ins_qj_busy;

   function automatic logic tag_hit(input logic               bus_valid,
                                    input logic [ROB_BIT-1:0] bus_tag,
                                    input logic [ROB_BIT-1:0] tag);
      return bus_valid && (bus_tag == tag);
   endfunction

   assign free_vec  = ~busy_q;
   assign ready_vec = busy_q & ~qi_busy_q & ~qj_busy_q;
   assign full      = &busy_q;

   rs_pick_lowest #(.N(RS_SIZE), .W(RS_BIT)) u_free_pick (
      .req   (free_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_pick_lowest #(.N(RS_SIZE), .W(RS_BIT)) u_ready_pick (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (ready_idx)
   );

   // Operands arriving with the op may already be on a CDB this cycle.
   always_comb begin
      ins_vi      = in_vi;
      ins_qi_busy = in_qi_busy;
      ins_vj      = in_vj;
      ins_qj_busy = in_qj_busy && !in_has_imm;
      if (ins_qi_busy) begin
         if (tag_hit(cdb_alu_valid, cdb_alu_rob, in_qi)) begin
            ins_vi      = cdb_alu_val;
            ins_qi_busy = 1'b0;
         end else if (tag_hit(cdb_lsb_valid, cdb_lsb_rob, in_qi)) begin
            ins_vi      = cdb_lsb_val;
            ins_qi_busy = 1'b0;
         end
      end
      if (ins_qj_busy) begin
         if (tag_hit(cdb_alu_valid, cdb_alu_rob, in_qj)) begin
            ins_vj      = cdb_alu_val;
            ins_qj_busy = 1'b0;
         end else if (tag_hit(cdb_lsb_valid, cdb_lsb_rob, in_qj)) begin
            ins_vj      = cdb_lsb_val;
            ins_qj_busy = 1'b0;
         end
      end
   end

   // Wakeup, dispatch and insert all read pre-edge state, so they never collide.
   always_comb begin
      busy_d        = busy_q;
      qi_busy_d     = qi_busy_q;
      qj_busy_d     = qj_busy_q;
      add_d         = add_q;
      has_imm_d     = has_imm_q;
      op_d          = op_q;
      imm_d         = imm_q;
      vi_d          = vi_q;
      vj_d          = vj_q;
      qi_d          = qi_q;
      qj_d          = qj_q;
      rob_d         = rob_q;
      alu_valid_d   = alu_valid_q;
      alu_vi_d      = alu_vi_q;
      alu_vj_d      = alu_vj_q;
      alu_imm_d     = alu_imm_q;
      alu_op_d      = alu_op_q;
      alu_has_imm_d = alu_has_imm_q;
      alu_add_d     = alu_add_q;
      alu_rob_d     = alu_rob_q;

      if (rdy_in) begin
         if (clear) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i] && qi_busy_q[i]) begin
                  if (tag_hit(cdb_alu_valid, cdb_alu_rob, qi_q[i])) begin
                     vi_d[i]      = cdb_alu_val;
                     qi_busy_d[i] = 1'b0;
                  end else if (tag_hit(cdb_lsb_valid, cdb_lsb_rob, qi_q[i])) begin
                     vi_d[i]      = cdb_lsb_val;
                     qi_busy_d[i] = 1'b0;
                  end
               end
               if (busy_q[i] && qj_busy_q[i]) begin
                  if (tag_hit(cdb_alu_valid, cdb_alu_rob, qj_q[i])) begin
                     vj_d[i]      = cdb_alu_val;
                     qj_busy_d[i] = 1'b0;
                  end else if (tag_hit(cdb_lsb_valid, cdb_lsb_rob, qj_q[i])) begin
                     vj_d[i]      = cdb_lsb_val;
                     qj_busy_d[i] = 1'b0;
                  end
               end
            end

            alu_valid_d = ready_found;
            if (ready_found) begin
               alu_vi_d          = vi_q[ready_idx];
               alu_vj_d          = vj_q[ready_idx];
               alu_imm_d         = imm_q[ready_idx];
               alu_op_d          = op_q[ready_idx];
               alu_has_imm_d     = has_imm_q[ready_idx];
               alu_add_d         = add_q[ready_idx];
               alu_rob_d         = rob_q[ready_idx];
               busy_d[ready_idx] = 1'b0;
            end

            if (in_valid && free_found) begin
               busy_d[free_idx]    = 1'b1;
               op_d[free_idx]      = alu_op_e'(in_op);
               add_d[free_idx]     = in_op_addition;
               has_imm_d[free_idx] = in_has_imm;
               imm_d[free_idx]     = in_imm;
               vi_d[free_idx]      = ins_vi;
               vj_d[free_idx]      = ins_vj;
               qi_busy_d[free_idx] = ins_qi_busy;
               qj_busy_d[free_idx] = ins_qj_busy;
               qi_d[free_idx]      = in_qi;
               qj_d[free_idx]      = in_qj;
               rob_d[free_idx]     = in_rob_entry;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q        <= '0;
         qi_busy_q     <= '0;
         qj_busy_q     <= '0;
         alu_valid_q   <= 1'b0;
         alu_vi_q      <= '0;
         alu_vj_q      <= '0;
         alu_imm_q     <= '0;
         alu_op_q      <= AddSub;
         alu_has_imm_q <= 1'b0;
         alu_add_q     <= 1'b0;
         alu_rob_q     <= '0;
      end else begin
         busy_q        <= busy_d;
         qi_busy_q     <= qi_busy_d;
         qj_busy_q     <= qj_busy_d;
         alu_valid_q   <= alu_valid_d;
         alu_vi_q      <= alu_vi_d;
         alu_vj_q      <= alu_vj_d;
         alu_imm_q     <= alu_imm_d;
         alu_op_q      <= alu_op_d;
         alu_has_imm_q <= alu_has_imm_d;
         alu_add_q     <= alu_add_d;
         alu_rob_q     <= alu_rob_d;
      end
   end

   // Entry payload is only meaningful while busy, so it needs no reset.
   always_ff @(posedge clk_in) begin
      add_q     <= add_d;
      has_imm_q <= has_imm_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      vi_q      <= vi_d;
      vj_q      <= vj_d;
      qi_q      <= qi_d;
      qj_q      <= qj_d;
      rob_q     <= rob_d;
   end

   assign alu_valid       = alu_valid_q;
   assign alu_vi          = alu_vi_q;
   assign alu_vj          = alu_vj_q;
   assign alu_imm         = alu_imm_q;
   assign alu_op          = alu_op_q;
   assign alu_has_imm     = alu_has_imm_q;
   assign alu_op_addition = alu_add_q;
   assign alu_rob_entry   = alu_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: a slot-list model of the station predicts every output each
// cycle, and directed scenarios pin key results with hand-computed literals.
module tb_alu_rs;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear;
   logic        in_valid, in_op_addition, in_has_imm, in_qi_busy, in_qj_busy;
   logic [2:0]  in_op;
   logic [4:0]  in_imm;
   logic [31:0] in_vi, in_vj;
   logic [3:0]  in_qi, in_qj, in_rob_entry;
   logic        full;
   logic        cdb_alu_valid, cdb_lsb_valid;
   logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
   logic [31:0] cdb_alu_val, cdb_lsb_val;
   logic        alu_valid, alu_has_imm, alu_op_addition;
   logic [31:0] alu_vi, alu_vj;
   logic [4:0]  alu_imm;
   logic [2:0]  alu_op;
   logic [3:0]  alu_rob_entry;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk_in = ~clk_in;

   alu_rs dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .clear           (clear),
      .in_valid        (in_valid),
      .in_op           (in_op),
      .in_op_addition  (in_op_addition),
      .in_has_imm      (in_has_imm),
      .in_imm          (in_imm),
      .in_vi           (in_vi),
      .in_vj           (in_vj),
      .in_qi_busy      (in_qi_busy),
      .in_qj_busy      (in_qj_busy),
      .in_qi           (in_qi),
      .in_qj           (in_qj),
      .in_rob_entry    (in_rob_entry),
      .full            (full),
      .cdb_alu_valid   (cdb_alu_valid),
      .cdb_alu_rob     (cdb_alu_rob),
      .cdb_alu_val     (cdb_alu_val),
      .cdb_lsb_valid   (cdb_lsb_valid),
      .cdb_lsb_rob     (cdb_lsb_rob),
      .cdb_lsb_val     (cdb_lsb_val),
      .alu_valid       (alu_valid),
      .alu_vi          (alu_vi),
      .alu_vj          (alu_vj),
      .alu_imm         (alu_imm),
      .alu_op          (alu_op),
      .alu_has_imm     (alu_has_imm),
      .alu_op_addition (alu_op_addition),
      .alu_rob_entry   (alu_rob_entry)
   );

   typedef struct {
      bit        busy;
      bit [2:0]  op;
      bit        add;
      bit        has_imm;
      bit [4:0]  imm;
      bit [31:0] vi, vj;
      bit        pi, pj;
      bit [3:0]  ti, tj, rob;
   } ent_t;

   ent_t      m_rs [8];
   ent_t      pre  [8];
   ent_t      nent;
   bit        m_valid, m_add, m_has_imm;
   bit [31:0] m_vi, m_vj;
   bit [4:0]  m_imm;
   bit [2:0]  m_op;
   bit [3:0]  m_rob;
   int        disp, slot;
   bit [32:0] hit;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [32:0] snoop(input bit [3:0] tag);
      if (cdb_alu_valid && cdb_alu_rob == tag) return {1'b1, cdb_alu_val};
      if (cdb_lsb_valid && cdb_lsb_rob == tag) return {1'b1, cdb_lsb_val};
      return 33'd0;
   endfunction

   function automatic bit modelFull();
      for (int i = 0; i < 8; i++) if (!m_rs[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 8; i++) m_rs[i].busy = 1'b0;
      m_valid = 0; m_vi = 0; m_vj = 0; m_imm = 0; m_op = 0;
      m_has_imm = 0; m_add = 0; m_rob = 0;
   endtask

   // One clock edge of the station as the rules describe it.
   task automatic modelEdge();
      if (!rst_in) begin
         modelReset();
      end else if (rdy_in) begin
         if (clear) begin
            for (int i = 0; i < 8; i++) m_rs[i].busy = 1'b0;
            m_valid = 1'b0;
         end else begin
            pre  = m_rs;
            disp = -1;
            slot = -1;
            for (int i = 0; i < 8; i++) begin
               if (disp < 0 && pre[i].busy && !pre[i].pi && !pre[i].pj) disp = i;
               if (slot < 0 && !pre[i].busy) slot = i;
            end
            for (int i = 0; i < 8; i++) begin
               if (!m_rs[i].busy) continue;
               if (m_rs[i].pi) begin
                  hit = snoop(m_rs[i].ti);
                  if (hit[32]) begin m_rs[i].vi = hit[31:0]; m_rs[i].pi = 1'b0; end
               end
               if (m_rs[i].pj) begin
                  hit = snoop(m_rs[i].tj);
                  if (hit[32]) begin m_rs[i].vj = hit[31:0]; m_rs[i].pj = 1'b0; end
               end
            end
            m_valid = (disp >= 0);
            if (disp >= 0) begin
               m_vi = pre[disp].vi; m_vj = pre[disp].vj; m_imm = pre[disp].imm;
               m_op = pre[disp].op; m_has_imm = pre[disp].has_imm;
               m_add = pre[disp].add; m_rob = pre[disp].rob;
               m_rs[disp].busy = 1'b0;
            end
            if (in_valid && slot >= 0) begin
               nent.busy = 1'b1; nent.op = in_op; nent.add = in_op_addition;
               nent.has_imm = in_has_imm; nent.imm = in_imm;
               nent.vi = in_vi; nent.vj = in_vj;
               nent.ti = in_qi; nent.tj = in_qj; nent.rob = in_rob_entry;
               nent.pi = in_qi_busy;
               nent.pj = in_qj_busy && !in_has_imm;
               if (nent.pi) begin
                  hit = snoop(in_qi);
                  if (hit[32]) begin nent.vi = hit[31:0]; nent.pi = 1'b0; end
               end
               if (nent.pj) begin
                  hit = snoop(in_qj);
                  if (hit[32]) begin nent.vj = hit[31:0]; nent.pj = 1'b0; end
               end
               m_rs[slot] = nent;
            end
         end
      end
   endtask

   always @(negedge clk_in) begin
      if (cmp_en) begin
         checkOutput("cyc_full", full, modelFull());
         checkOutput("cyc_valid", alu_valid, m_valid);
         checkOutput("cyc_vi", alu_vi, m_vi);
         if (!m_has_imm) checkOutput("cyc_vj", alu_vj, m_vj);
         checkOutput("cyc_imm", alu_imm, m_imm);
         checkOutput("cyc_op", alu_op, m_op);
         checkOutput("cyc_has_imm", alu_has_imm, m_has_imm);
         checkOutput("cyc_add", alu_op_addition, m_add);
         checkOutput("cyc_rob", alu_rob_entry, m_rob);
      end
   end

   task automatic stepCycle();
      @(posedge clk_in);
      modelEdge();
      @(negedge clk_in);
   endtask

   task automatic idle();
      in_valid = 0; clear = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0;
   endtask

   task automatic applyStimulus(input bit v, input bit [2:0] op, input bit add,
                                input bit hi, input bit [4:0] imm,
                                input bit [31:0] vi, input bit pi, input bit [3:0] ti,
                                input bit [31:0] vj, input bit pj, input bit [3:0] tj,
                                input bit [3:0] rob);
      in_valid = v; in_op = op; in_op_addition = add; in_has_imm = hi; in_imm = imm;
      in_vi = vi; in_qi_busy = pi; in_qi = ti;
      in_vj = vj; in_qj_busy = pj; in_qj = tj; in_rob_entry = rob;
   endtask

   task automatic setAluCdb(input bit [3:0] tag, input bit [31:0] val);
      cdb_alu_valid = 1; cdb_alu_rob = tag; cdb_alu_val = val;
   endtask

   task automatic setLsbCdb(input bit [3:0] tag, input bit [31:0] val);
      cdb_lsb_valid = 1; cdb_lsb_rob = tag; cdb_lsb_val = val;
   endtask

   initial begin
      rst_in = 0; rdy_in = 1;
      idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cdb_alu_rob = 0; cdb_alu_val = 0; cdb_lsb_rob = 0; cdb_lsb_val = 0;
      modelReset();
      repeat (2) @(negedge clk_in);
      cmp_en = 1;
      checkOutput("reset_valid", alu_valid, 0);
      checkOutput("reset_full", full, 0);
      checkOutput("reset_vi", alu_vi, 0);
      rst_in = 1;
      stepCycle();

      // Ready insert: x1=5, x2=7 issues one edge after insertion.
      applyStimulus(1, 3'b000, 0, 0, 0, 5, 0, 0, 7, 0, 0, 4'd1);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("ready_valid", alu_valid, 1);
      checkOutput("ready_vi", alu_vi, 5);
      checkOutput("ready_vj", alu_vj, 7);
      checkOutput("ready_op", alu_op, 0);
      checkOutput("ready_rob", alu_rob_entry, 1);
      stepCycle();
      checkOutput("ready_drop", alu_valid, 0);

      // Wakeup from the LSB CDB: sub 10 - [tag 3].
      applyStimulus(1, 3'b000, 1, 0, 0, 10, 0, 0, 0, 1, 4'd3, 4'd2);
      stepCycle();
      idle();
      checkOutput("wake_pending", alu_valid, 0);
      setLsbCdb(4'd3, 32'd4);
      stepCycle();
      idle();
      checkOutput("wake_same_edge", alu_valid, 0);
      stepCycle();
      checkOutput("wake_valid", alu_valid, 1);
      checkOutput("wake_vi", alu_vi, 10);
      checkOutput("wake_vj", alu_vj, 4);
      checkOutput("wake_add", alu_op_addition, 1);
      checkOutput("wake_rob", alu_rob_entry, 2);

      // Bypass: the operand's tag is broadcast on the insert cycle itself.
      applyStimulus(1, 3'b100, 0, 0, 0, 0, 1, 4'd5, 3, 0, 0, 4'd3);
      setAluCdb(4'd5, 32'h55);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("bypass_valid", alu_valid, 1);
      checkOutput("bypass_vi", alu_vi, 32'h55);
      checkOutput("bypass_op", alu_op, 3'b100);

      // Immediate form: a pending qj is ignored when has_imm is set.
      applyStimulus(1, 3'b001, 0, 1, 5'd2, 9, 0, 0, 32'hDEAD, 1, 4'd7, 4'd4);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("imm_valid", alu_valid, 1);
      checkOutput("imm_has_imm", alu_has_imm, 1);
      checkOutput("imm_imm", alu_imm, 2);
      checkOutput("imm_rob", alu_rob_entry, 4);
      stepCycle();

      // Fill all eight slots pending on tag 9; the ninth insert is dropped.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 3'b110, 0, 0, 0, 0, 1, 4'd9, 32'(100 + i), 0, 0, 4'(i));
         stepCycle();
      end
      idle();
      checkOutput("fill_full", full, 1);
      applyStimulus(1, 3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'd15);
      stepCycle();
      idle();
      checkOutput("fill_ninth_full", full, 1);
      setAluCdb(4'd9, 32'h99);
      stepCycle();
      idle();
      checkOutput("fill_woken_nodisp", alu_valid, 0);
      stepCycle();
      checkOutput("fill_d0_valid", alu_valid, 1);
      checkOutput("fill_d0_rob", alu_rob_entry, 0);
      checkOutput("fill_d0_vi", alu_vi, 32'h99);
      checkOutput("fill_d0_vj", alu_vj, 100);
      checkOutput("fill_d0_full", full, 0);
      applyStimulus(1, 3'b010, 0, 0, 0, 1, 0, 0, 2, 0, 0, 4'd12);
      stepCycle();
      idle();
      checkOutput("fill_d1_rob", alu_rob_entry, 1);
      stepCycle();
      checkOutput("fill_reuse_rob", alu_rob_entry, 12);
      for (int k = 2; k < 8; k++) begin
         stepCycle();
         checkOutput("fill_order_rob", alu_rob_entry, k);
      end
      stepCycle();
      checkOutput("fill_drained", alu_valid, 0);

      // Clear kills an op sitting on the ALU outputs.
      applyStimulus(1, 3'b000, 0, 0, 0, 3, 0, 0, 4, 0, 0, 4'd13);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("clr_pre_valid", alu_valid, 1);
      clear = 1;
      stepCycle();
      idle();
      checkOutput("clr_valid", alu_valid, 0);

      // Clear while full with a woken op; a racing insert loses to clear.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 3'b000, 0, 0, 0, 0, 1, (i == 0) ? 4'd11 : 4'd10, 1, 0, 0, 4'(i));
         stepCycle();
      end
      idle();
      checkOutput("clr_full", full, 1);
      setAluCdb(4'd11, 32'd1);
      stepCycle();
      idle();
      clear = 1;
      applyStimulus(1, 3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'd14);
      stepCycle();
      idle();
      checkOutput("clr_after_valid", alu_valid, 0);
      checkOutput("clr_after_full", full, 0);
      setLsbCdb(4'd10, 32'd2);
      stepCycle();
      idle();
      repeat (2) stepCycle();
      checkOutput("clr_stale", alu_valid, 0);

      // rdy_in low freezes outputs and ignores inputs.
      applyStimulus(1, 3'b011, 0, 0, 0, 40, 0, 0, 41, 0, 0, 4'd4);
      stepCycle();
      applyStimulus(1, 3'b011, 0, 0, 0, 50, 0, 0, 51, 0, 0, 4'd5);
      stepCycle();
      idle();
      checkOutput("rdy_pre_rob", alu_rob_entry, 4);
      rdy_in = 0;
      applyStimulus(1, 3'b011, 0, 0, 0, 60, 0, 0, 61, 0, 0, 4'd6);
      repeat (3) begin
         stepCycle();
         checkOutput("rdy_hold_valid", alu_valid, 1);
         checkOutput("rdy_hold_rob", alu_rob_entry, 4);
         checkOutput("rdy_hold_vi", alu_vi, 40);
      end
      idle();
      rdy_in = 1;
      stepCycle();
      checkOutput("rdy_resume_rob", alu_rob_entry, 5);
      checkOutput("rdy_resume_vi", alu_vi, 50);
      stepCycle();
      checkOutput("rdy_ignored", alu_valid, 0);

      // Asynchronous reset in the middle of activity.
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1, 3'b000, 0, 0, 0, 0, 1, 4'd12, 0, 0, 0, 4'(i));
         stepCycle();
      end
      applyStimulus(1, 3'b000, 0, 0, 0, 70, 0, 0, 71, 0, 0, 4'd7);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("rst_pre_valid", alu_valid, 1);
      #2;
      rst_in = 0;
      modelReset();
      #1;
      checkOutput("rst_async_valid", alu_valid, 0);
      checkOutput("rst_async_full", full, 0);
      checkOutput("rst_async_vi", alu_vi, 0);
      checkOutput("rst_async_rob", alu_rob_entry, 0);
      @(negedge clk_in);
      stepCycle();
      rst_in = 1;
      setAluCdb(4'd12, 32'd5);
      stepCycle();
      idle();
      repeat (2) stepCycle();
      checkOutput("rst_no_dispatch", alu_valid, 0);
      checkOutput("rst_no_full", full, 0);

      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
